// File: rtl/seg_scroll_ascii.sv
// Purpose: ASCII message buffer multiplexed onto NUM_DIGITS 7-segment digits with static/wrap/one-shot scroll and 16-level PWM.
// Latency: digit_sel/seg_out registered, 1 clk after digit index or PWM phase changes; buffer writes visible after the next edge.
// Backpressure: none; writes, start and stop are accepted every cycle, stop beats start.
module seg_scroll_ascii #(
    parameter int NUM_DIGITS  = 4,
    parameter int MSG_DEPTH   = 32,
    parameter int REFRESH_DIV = 25000,
    parameter int SCROLL_DIV  = 25000000,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
    input  logic [7:0]                   wr_data,
    input  logic [$clog2(MSG_DEPTH):0]   msg_len,
    input  logic [1:0]                   mode,
    input  logic                         start,
    input  logic                         stop,
    input  logic [3:0]                   brightness,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_DIGITS-1:0]        digit_sel,
    output logic [7:0]                   seg_out
);
    localparam int   AW     = $clog2(MSG_DEPTH);
    localparam int   DW     = $clog2(NUM_DIGITS);
    localparam int   PH_DIV = REFRESH_DIV / 16;
    localparam int   SUBW   = (PH_DIV > 1) ? $clog2(PH_DIV) : 1;
    localparam int   SCW    = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic INV    = (ACTIVE_LOW != 0);

    typedef logic [AW:0] len_t;
    localparam len_t DEPTH_L = len_t'(MSG_DEPTH);

    typedef enum logic {IDLE, SCROLL} state_t;

    // ASCII to segment pattern (bit0..6 = a..g, bit7 = dp); lowercase folds to uppercase.
    function automatic logic [7:0] font(input logic [7:0] c);
        logic [7:0] u;
        u = ((c >= 8'h61) && (c <= 8'h7A)) ? (c - 8'h20) : c;
        case (u)
            8'h30: font = 8'h3F;  8'h31: font = 8'h06;  8'h32: font = 8'h5B;  8'h33: font = 8'h4F;
            8'h34: font = 8'h66;  8'h35: font = 8'h6D;  8'h36: font = 8'h7D;  8'h37: font = 8'h07;
            8'h38: font = 8'h7F;  8'h39: font = 8'h6F;
            8'h41: font = 8'h77;  8'h42: font = 8'h7C;  8'h43: font = 8'h39;  8'h44: font = 8'h5E;
            8'h45: font = 8'h79;  8'h46: font = 8'h71;  8'h47: font = 8'h3D;  8'h48: font = 8'h76;
            8'h49: font = 8'h30;  8'h4A: font = 8'h1E;  8'h4B: font = 8'h75;  8'h4C: font = 8'h38;
            8'h4D: font = 8'h37;  8'h4E: font = 8'h54;  8'h4F: font = 8'h3F;  8'h50: font = 8'h73;
            8'h51: font = 8'h67;  8'h52: font = 8'h50;  8'h53: font = 8'h6D;  8'h54: font = 8'h78;
            8'h55: font = 8'h3E;  8'h56: font = 8'h1C;  8'h57: font = 8'h2A;  8'h58: font = 8'h49;
            8'h59: font = 8'h6E;  8'h5A: font = 8'h5B;
            8'h2D: font = 8'h40;  // '-'
            8'h5F: font = 8'h08;  // '_'
            8'h2E: font = 8'h80;  // '.'
            default: font = 8'h00;
        endcase
    endfunction

    logic [7:0]      msg_mem [MSG_DEPTH];
    len_t            len_c;
    logic [SUBW-1:0] sub_cnt;
    logic [3:0]      phase;
    logic [DW-1:0]   dig;
    len_t            ptr, ptr_nxt, ptr_inc;
    logic            slot_end, frame_end, wrap_ptr;

    state_t          state, state_nxt;
    logic [SCW-1:0]  scr_cnt, scr_cnt_nxt;
    len_t            offset, offset_nxt, offset_inc;
    logic [1:0]      mode_l, mode_l_nxt;
    logic            done_nxt, start_ok;

    logic [7:0]            cur_seg;
    logic                  lit;
    logic [NUM_DIGITS-1:0] sel_raw;

    // Lengths beyond the buffer are treated as the full buffer.
    assign len_c = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;

    // Message buffer write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) msg_mem[wr_addr] <= wr_data;
    end

    // The refresh prescaler is split into PWM phase (upper) and sub-phase (lower) so no divider is needed.
    assign slot_end  = (phase == 4'd15) && (sub_cnt == SUBW'(PH_DIV - 1));
    assign frame_end = slot_end && (dig == DW'(NUM_DIGITS - 1));
    assign busy      = (state == SCROLL);
    // While scrolling the latched mode decides pointer wrap; when idle the live mode does.
    assign wrap_ptr  = ((state == SCROLL) ? mode_l : mode) == 2'd1;

    // Character pointer for the next digit: reload at frame start, otherwise step with wrap or saturation.
    always_comb begin
        ptr_inc = ptr + 1'b1;
        ptr_nxt = ptr;
        if (frame_end)
            ptr_nxt = offset;
        else if (wrap_ptr)
            ptr_nxt = (ptr_inc >= len_c) ? '0 : ptr_inc;
        else
            ptr_nxt = (ptr >= len_c) ? len_c : ptr_inc;
    end

    // Refresh prescaler, digit index and character pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_cnt <= '0;
            phase   <= '0;
            dig     <= '0;
            ptr     <= '0;
        end else begin
            if (sub_cnt == SUBW'(PH_DIV - 1)) begin
                sub_cnt <= '0;
                phase   <= phase + 4'd1;
            end else begin
                sub_cnt <= sub_cnt + 1'b1;
            end
            if (slot_end) begin
                dig <= frame_end ? '0 : dig + 1'b1;
                ptr <= ptr_nxt;
            end
        end
    end

    assign start_ok = start && ((mode == 2'd1) || (mode == 2'd2)) && (len_c != '0);

    // Scroll FSM next state: stop wins, a valid start (re)enters SCROLL, otherwise step offset on counter wrap.
    always_comb begin
        state_nxt   = state;
        scr_cnt_nxt = scr_cnt;
        offset_nxt  = offset;
        mode_l_nxt  = mode_l;
        done_nxt    = 1'b0;
        offset_inc  = offset + 1'b1;
        if (stop) begin
            state_nxt   = IDLE;
            scr_cnt_nxt = '0;
            offset_nxt  = '0;
        end else if (start_ok) begin
            state_nxt   = SCROLL;
            scr_cnt_nxt = '0;
            offset_nxt  = '0;
            mode_l_nxt  = mode;
        end else if (state == SCROLL) begin
            if (scr_cnt == SCW'(SCROLL_DIV - 1)) begin
                scr_cnt_nxt = '0;
                // Uses live msg_len, so a shrunken message wraps or completes on this step.
                if (offset_inc >= len_c) begin
                    offset_nxt = '0;
                    if (mode_l != 2'd1) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    offset_nxt = offset_inc;
                end
            end else begin
                scr_cnt_nxt = scr_cnt + 1'b1;
            end
        end
    end

    // Scroll FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            scr_cnt <= '0;
            offset  <= '0;
            mode_l  <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            scr_cnt <= scr_cnt_nxt;
            offset  <= offset_nxt;
            mode_l  <= mode_l_nxt;
            done    <= done_nxt;
        end
    end

    assign cur_seg = ((ptr >= len_c) || (len_c == '0)) ? 8'h00 : font(msg_mem[ptr[AW-1:0]]);
    assign lit     = (phase <= brightness);
    assign sel_raw = lit ? (NUM_DIGITS'(1) << dig) : '0;

    // Output register with optional polarity inversion for active-low boards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_sel <= {NUM_DIGITS{INV}};
            seg_out   <= {8{INV}};
        end else begin
            digit_sel <= sel_raw ^ {NUM_DIGITS{INV}};
            seg_out   <= cur_seg ^ {8{INV}};
        end
    end

endmodule

// File: tb/tb_seg_scroll_ascii.sv
// Directed bench for seg_scroll_ascii: static refresh/font, PWM, one-shot and wrap scroll, edge cases, async reset.
module tb_seg_scroll_ascii;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [4:0] msg_len = '0;
    logic [1:0] mode = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] brightness = 4'd15;
    logic       busy, done;
    logic [3:0] digit_sel;
    logic [7:0] seg_out;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_seen = 0;
    logic [7:0] exp_seg [4];

    seg_scroll_ascii #(
        .NUM_DIGITS(4), .MSG_DEPTH(16), .REFRESH_DIV(16), .SCROLL_DIV(256), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .msg_len(msg_len), .mode(mode), .start(start), .stop(stop), .brightness(brightness),
        .busy(busy), .done(done), .digit_sel(digit_sel), .seg_out(seg_out)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; after edge k the outputs show slot ((k-1)/16)%4, phase (k-1)%16.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (done) done_seen <= done_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic write_char(input int addr, input logic [7:0] ch);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = addr[3:0]; wr_data = ch;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic set_exp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        exp_seg[0] = a; exp_seg[1] = b; exp_seg[2] = c; exp_seg[3] = d;
    endtask

    // Checks digit_sel timing/PWM every cycle and the segment pattern whenever a digit is lit.
    task automatic sample_frame(input string tag, input int n);
        int d, ph;
        logic [3:0] es;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d  = ((cyc - 1) / 16) % 4;
            ph = (cyc - 1) % 16;
            es = (ph <= int'(brightness)) ? 4'(1 << d) : 4'b0000;
            check({tag, "_sel"}, 32'(digit_sel), 32'(es));
            if (es != 4'b0000) check({tag, "_seg"}, 32'(seg_out), 32'(exp_seg[d]));
        end
    endtask

    task automatic count_lit(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (digit_sel != 4'b0000) c++;
        end
    endtask

    initial begin
        int c, i_done, n_done, done_before;
        logic e_seen;

        // Reset state
        wait_cyc(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sel", 32'(digit_sel), 32'd0);
        check("rst_seg", 32'(seg_out), 32'd0);
        reset = 1'b0;

        // Static "HELO"
        msg_len = 5'd4; mode = 2'd0;
        write_char(0, "H"); write_char(1, "E"); write_char(2, "L"); write_char(3, "O");
        wait_cyc(70);
        set_exp(8'h76, 8'h79, 8'h38, 8'h3F);
        sample_frame("static", 64);

        // PWM brightness
        brightness = 4'd0;
        sample_frame("pwm0", 64);
        count_lit(64, c);
        check("pwm0_cnt", 32'(c), 32'd4);
        brightness = 4'd7;
        sample_frame("pwm7", 64);
        count_lit(64, c);
        check("pwm7_cnt", 32'(c), 32'd32);
        brightness = 4'd15;

        // One-shot scroll "HELLO"
        write_char(4, "O"); write_char(3, "L");
        msg_len = 5'd5; mode = 2'd2;
        pulse_start();
        check("os_busy", 32'(busy), 32'd1);
        n_done = 0; i_done = 0; e_seen = 1'b0;
        for (int i = 1; i <= 1400; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (i_done == 0) i_done = i;
            end
            if (i == 1279) check("os_busy_pre", 32'(busy), 32'd1);
            if (i == 1280) check("os_busy_post", 32'(busy), 32'd0);
            if (i >= 330 && i <= 500 && digit_sel == 4'b0001 && !e_seen) begin
                e_seen = 1'b1;
                check("os_step1_d0", 32'(seg_out), 32'h79);
            end
        end
        check("os_done_cnt", 32'(n_done), 32'd1);
        check("os_done_at", 32'(i_done), 32'd1280);
        check("os_d0_seen", 32'(e_seen), 32'd1);
        set_exp(8'h76, 8'h79, 8'h38, 8'h38);
        sample_frame("os_after", 64);

        // Wrap scroll "12"
        write_char(0, "1"); write_char(1, "2");
        msg_len = 5'd2; mode = 2'd1;
        done_before = done_seen;
        pulse_start();
        check("wr_busy", 32'(busy), 32'd1);
        wait_cyc(70);
        set_exp(8'h06, 8'h5B, 8'h06, 8'h5B);
        sample_frame("wrap0", 64);
        wait_cyc(185);
        set_exp(8'h5B, 8'h06, 8'h5B, 8'h06);
        sample_frame("wrap1", 64);
        wait_cyc(192);
        set_exp(8'h06, 8'h5B, 8'h06, 8'h5B);
        sample_frame("wrap2", 64);
        check("wr_busy_late", 32'(busy), 32'd1);
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        check("wr_stop_busy", 32'(busy), 32'd0);
        wait_cyc(70);
        sample_frame("wr_stopped", 64);
        check("wr_no_done", 32'(done_seen - done_before), 32'd0);

        // start ignored with msg_len = 0 or mode 0
        msg_len = 5'd0; mode = 2'd1;
        pulse_start();
        check("len0_busy", 32'(busy), 32'd0);
        wait_cyc(70);
        set_exp(8'h00, 8'h00, 8'h00, 8'h00);
        sample_frame("len0", 64);
        msg_len = 5'd2; mode = 2'd0;
        pulse_start();
        check("mode0_busy", 32'(busy), 32'd0);

        // start and stop together while busy
        mode = 2'd1;
        pulse_start();
        check("ss_busy", 32'(busy), 32'd1);
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        check("ss_idle", 32'(busy), 32'd0);

        // Font corners and blanking past msg_len
        mode = 2'd0; msg_len = 5'd4;
        write_char(0, 8'h7F); write_char(1, "h"); write_char(2, "-"); write_char(3, ".");
        wait_cyc(70);
        set_exp(8'h00, 8'h76, 8'h40, 8'h80);
        sample_frame("font", 64);
        msg_len = 5'd3;
        wait_cyc(70);
        set_exp(8'h00, 8'h76, 8'h40, 8'h00);
        sample_frame("blank", 64);
        write_char(3, "_");
        msg_len = 5'd20;
        wait_cyc(70);
        set_exp(8'h00, 8'h76, 8'h40, 8'h08);
        sample_frame("clamp", 64);

        // Async reset mid-scroll
        write_char(0, "1"); write_char(1, "2");
        msg_len = 5'd2; mode = 2'd1;
        pulse_start();
        wait_cyc(100);
        check("ar_busy_pre", 32'(busy), 32'd1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_sel", 32'(digit_sel), 32'd0);
        check("ar_seg", 32'(seg_out), 32'd0);
        wait_cyc(2);
        reset = 1'b0;
        set_exp(8'h06, 8'h5B, 8'h06, 8'h5B);
        sample_frame("ar_after", 64);
        check("ar_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
